operand_stage: RTL

Register-read pipeline stage between instruction decode and the ALU. Drives the RegFile read addresses, captures both operands into an output pipeline register, and forwards same-cycle writeback data. A per-register busy scoreboard stalls decode on RAW/WAW hazards against writes still in flight downstream. Valid/ready handshakes on both sides let the ALU stage back-pressure decode.

---
 rtl/operand_stage.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/operand_stage.sv
// operand_stage: register-read stage between decode and the ALU.
// It drives the RegFile read addresses and registers both operands, bypassing
// same-cycle writeback data around the RegFile. A per-register busy scoreboard
// stalls decode on RAW/WAW hazards, and a valid/ready pair on each side lets the
// ALU back-pressure decode.
module operand_stage #(
    parameter int W  = 8,   // data path width, matches RegFile
    parameter int A  = 4,   // register address width
    parameter int CW = 16   // stall counter width
) (
    input  logic          Clk,
    input  logic          Reset,
    // decode side
    input  logic          InValid,
    output logic          InReady,
    input  logic [A-1:0]  InRa,
    input  logic [A-1:0]  InRb,
    input  logic [A-1:0]  InRd,
    input  logic          InWrEn,
    input  logic [3:0]    InOp,
    // RegFile read ports
    output logic [A-1:0]  RaddrA,
    output logic [A-1:0]  RaddrB,
    input  logic [W-1:0]  DataOutA,
    input  logic [W-1:0]  DataOutB,
    // writeback bus, shared with the RegFile write port
    input  logic          WbEn,
    input  logic [A-1:0]  WbAddr,
    input  logic [W-1:0]  WbData,
    // ALU side
    output logic          OutValid,
    input  logic          OutReady,
    output logic [W-1:0]  OutOpA,
    output logic [W-1:0]  OutOpB,
    output logic [A-1:0]  OutRd,
    output logic          OutWrEn,
    output logic [3:0]    OutOp,
    output logic [CW-1:0] StallCycles
);

    localparam int NR = 2 ** A;

    logic [NR-1:0] r_busy;
    logic [CW-1:0] r_stall;
    logic          r_out_valid;
    logic [W-1:0]  r_op_a;
    logic [W-1:0]  r_op_b;
    logic [A-1:0]  r_rd;
    logic          r_wr_en;
    logic [3:0]    r_op;

    logic          w_hit_a;
    logic          w_hit_b;
    logic          w_hit_d;
    logic          w_busy_a;
    logic          w_busy_b;
    logic          w_busy_d;
    logic          w_hazard;
    logic          w_accept;
    logic [W-1:0]  w_fwd_a;
    logic [W-1:0]  w_fwd_b;
    logic [NR-1:0] w_busy_next;

    // The read ports simply follow the source fields.
    assign RaddrA = InRa;
    assign RaddrB = InRb;

    // A writeback in this cycle retires the pending write on its address, so it
    // both clears the hazard and supplies the operand (the RegFile only sees it
    // at the coming edge).
    assign w_hit_a  = WbEn && (WbAddr == InRa);
    assign w_hit_b  = WbEn && (WbAddr == InRb);
    assign w_hit_d  = WbEn && (WbAddr == InRd);

    // Port A treats r0 as an ordinary register; port B's r0 is hardwired zero.
    assign w_busy_a = r_busy[InRa] && !w_hit_a;
    assign w_busy_b = (InRb != '0) && r_busy[InRb] && !w_hit_b;
    assign w_busy_d = InWrEn && r_busy[InRd] && !w_hit_d;
    assign w_hazard = w_busy_a || w_busy_b || w_busy_d;

    assign InReady  = !Reset && !w_hazard && (!r_out_valid || OutReady);
    assign w_accept = InValid && InReady;

    assign w_fwd_a  = w_hit_a ? WbData : DataOutA;
    assign w_fwd_b  = (InRb == '0) ? '0 : (w_hit_b ? WbData : DataOutB);

    // Scoreboard next state: writeback clears, a newly accepted writer sets.
    always_comb begin
        // NOTE: blocking assignments in combinational logic, with a full default
        // first so no path leaves w_busy_next unassigned (no latch). The set is
        // applied after the clear so a new writer to the same register wins.
        w_busy_next = r_busy;
        if (WbEn) begin
            w_busy_next[WbAddr] = 1'b0;
        end
        if (w_accept && InWrEn) begin
            w_busy_next[InRd] = 1'b1;
        end
    end

    // Scoreboard and saturating hazard-stall counter.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments only; the
        // scoreboard is a flop vector, so it is cleared by reset like any other
        // state.
        if (Reset) begin
            r_busy  <= '0;
            r_stall <= '0;
        end else begin
            r_busy <= w_busy_next;
            if (InValid && w_hazard && (r_stall != '1)) begin
                r_stall <= r_stall + CW'(1);
            end
        end
    end

    // Output pipeline register: load on accept, drain when consumed, else hold.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_out_valid <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_rd        <= '0;
            r_wr_en     <= 1'b0;
            r_op        <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_op_a      <= w_fwd_a;
            r_op_b      <= w_fwd_b;
            r_rd        <= InRd;
            r_wr_en     <= InWrEn;
            r_op        <= InOp;
        end else if (OutReady) begin
            r_out_valid <= 1'b0;
        end
    end

    assign OutValid    = r_out_valid;
    assign OutOpA      = r_op_a;
    assign OutOpB      = r_op_b;
    assign OutRd       = r_rd;
    assign OutWrEn     = r_wr_en;
    assign OutOp       = r_op;
    assign StallCycles = r_stall;

endmodule
